// File: rtl/aes_pkg.sv
// AES key-schedule support: key-length encoding, S-box, GF(2^8) doubling
// and per-key-length word/round counts.
package aes_pkg;

   typedef enum logic [1:0] {
      KEY_128 = 2'd0,
      KEY_192 = 2'd1,
      KEY_256 = 2'd2,
      KEY_BAD = 2'd3
   } key_len_t;

   localparam int AES_MAX_WORDS = 60;

   localparam logic [7:0] SBOX_TBL [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[b];
   endfunction

   // Multiply by x in GF(2^8) with the AES reduction polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [3:0] nk_of(input key_len_t k);
      case (k)
         KEY_192: return 4'd6;
         KEY_256: return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input key_len_t k);
      case (k)
         KEY_192: return 4'd12;
         KEY_256: return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: S-box applied independently to each byte of a 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);

   assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one word per clock through a
// single SubWord, full schedule held in a word store, round keys read by index.
//
// Handshake: start is sampled only while IDLE (busy=0). An accepted start
// raises busy on the next edge; done pulses for one cycle in FINISH, at which
// point key_valid and nr already describe the new schedule. start seen while
// busy is dropped, never queued.
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int MAX_WORDS    = AES_MAX_WORDS,
   parameter bit ZERO_INVALID = 1'b1
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         key_valid,
   output logic [3:0]   nr,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] w [0:MAX_WORDS-1];
   logic [5:0]  i;
   logic [5:0]  last_idx;
   logic [2:0]  p;
   logic [3:0]  nk_r;
   logic [3:0]  nr_r;
   logic [7:0]  rcon;

   logic [3:0]  nk_n;
   logic [3:0]  nr_n;
   logic        start_ok;
   logic [31:0] prev_w;
   logic [31:0] back_w;
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] temp;
   logic [31:0] new_w;
   logic [5:0]  rd_base;
   logic        rd_inside;
   logic        rd_ok;
   logic [127:0] rd_raw;

   assign dbg_state = state;

   // Decode the requested key length and qualify start.
   always_comb begin
      nk_n     = nk_of(key_len_t'(key_len));
      nr_n     = nr_of(key_len_t'(key_len));
      start_ok = (state == ST_IDLE) && start && (key_len != 2'd3);
   end

   // Select the SubWord input: rotated on the first word of each key period.
   always_comb begin
      prev_w = w[i - 6'd1];
      back_w = w[i - {2'b00, nk_r}];
      sub_in = (p == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
   end

   aes_subword u_subword (
      .word (sub_in),
      .sub  (sub_out)
   );

   // Form the next schedule word from the shared SubWord result.
   always_comb begin
      if (p == 3'd0)
         temp = sub_out ^ {rcon, 24'h0};
      else if ((nk_r == 4'd8) && (p == 3'd4))
         temp = sub_out;
      else
         temp = prev_w;
      new_w = back_w ^ temp;
   end

   // Word store: key words on accept, one expanded word per EXPAND cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (start_ok) begin
            for (int k = 0; k < 8; k++)
               if (k < int'(nk_n))
                  w[k] <= key_in[255-32*k -: 32];
         end else if (state == ST_EXPAND) begin
            w[i] <= new_w;
         end
      end
   end

   // Control FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         key_valid <= 1'b0;
         nr        <= 4'd0;
         i         <= 6'd0;
         p         <= 3'd0;
         rcon      <= 8'h00;
         nk_r      <= 4'd0;
         nr_r      <= 4'd0;
         last_idx  <= 6'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && (key_len == 2'd3)) begin
                  err <= 1'b1;
               end else if (start_ok) begin
                  nk_r      <= nk_n;
                  nr_r      <= nr_n;
                  last_idx  <= {nr_n, 2'b11};
                  i         <= {2'b00, nk_n};
                  p         <= 3'd0;
                  rcon      <= 8'h01;
                  key_valid <= 1'b0;
                  nr        <= 4'd0;
                  busy      <= 1'b1;
                  state     <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               if (p == 3'd0)
                  rcon <= xtime(rcon);
               p <= (p == 3'(nk_r - 4'd1)) ? 3'd0 : p + 3'd1;
               i <= i + 6'd1;
               if (i == last_idx) begin
                  state     <= ST_FINISH;
                  done      <= 1'b1;
                  key_valid <= 1'b1;
                  nr        <= nr_r;
               end
            end
            ST_FINISH: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Gather the four words of the addressed round key.
   always_comb begin
      rd_base   = {rk_idx, 2'b00};
      rd_inside = (int'(rd_base) + 3) < MAX_WORDS;
      rd_ok     = key_valid && (rk_idx <= nr);
      if (rd_inside)
         rd_raw = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
      else
         rd_raw = '0;
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (rst)
         rk_out <= '0;
      else
         rk_out <= (rd_ok || !ZERO_INVALID) ? rd_raw : '0;
   end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: FIPS-197 known answers plus random keys
// checked against a key-expansion model built from GF(2^8) arithmetic.
module tb_aes_key_schedule_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy;
   logic         done;
   logic         err;
   logic         key_valid;
   logic [3:0]   nr;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   logic [1:0]   dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   aes_key_schedule_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_len   (key_len),
      .key_in    (key_in),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .key_valid (key_valid),
      .nr        (nr),
      .rk_idx    (rk_idx),
      .rk_out    (rk_out),
      .dbg_state (dbg_state)
   );

   // ---------------- reference model ----------------
   logic [7:0]  ref_sbox [256];
   logic [31:0] m_w [60];
   int          m_nr    = 0;
   int          m_nr_nx = 0;
   bit          m_valid = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = 8'h00;
      logic [7:0] x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) r = r ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {ref_sbox[v[31:24]], ref_sbox[v[23:16]], ref_sbox[v[15:8]], ref_sbox[v[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int n);
      logic [7:0] r = 8'h01;
      for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   task automatic model_expand(input int len, input logic [255:0] key, output int words, output int nk);
      logic [31:0] t;
      nk      = 4 + 2 * len;
      m_nr_nx = nk + 6;
      words   = 4 * (m_nr_nx + 1);
      for (int k = 0; k < nk; k++) m_w[k] = key[255-32*k -: 32];
      for (int k = nk; k < words; k++) begin
         t = m_w[k-1];
         if (k % nk == 0)
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(k / nk), 24'h0};
         else if (nk > 6 && k % nk == 4)
            t = sub_word(t);
         m_w[k] = m_w[k-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int idx);
      if (!m_valid || idx > m_nr) return 128'h0;
      return {m_w[4*idx], m_w[4*idx+1], m_w[4*idx+2], m_w[4*idx+3]};
   endfunction

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q [$];
   int           done_q [$];
   bit           rd_req   = 0;
   bit           rd_req_d = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(posedge clk) rd_req_d <= rd_req;

   // Monitor: pops an expectation whenever the DUT presents a read or a done.
   always @(negedge clk) begin : monitor
      logic [127:0] e;
      int           dc;
      if (rd_req_d) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rk_out_unexpected actual=%0h required=none", rk_out);
         end else begin
            e = exp_q.pop_front();
            chk("rk_out", rk_out, e);
         end
      end
      if (done) begin
         if (done_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected actual=cycle%0d required=none", cyc);
         end else begin
            dc = done_q.pop_front();
            chk("done_cycle", 128'(cyc), 128'(dc));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic rd(input int idx, input logic [127:0] e);
      @(negedge clk);
      rk_idx = 4'(idx);
      rd_req = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((busy || done_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL wait_quiet actual=busy%0d_pending%0d required=idle", busy, done_q.size());
         done_q.delete();
      end
   endtask

   task automatic run(input int len, input logic [255:0] key);
      int words, nk;
      model_expand(len, key, words, nk);
      m_valid = 0;
      m_nr    = 0;
      @(negedge clk);
      start   = 1'b1;
      key_len = 2'(len);
      key_in  = key;
      done_q.push_back(cyc + words - nk + 1);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 128'(busy), 128'd1);
      wait_quiet();
      m_valid = 1;
      m_nr    = m_nr_nx;
      chk("key_valid_after_run", 128'(key_valid), 128'd1);
      chk("nr_after_run", 128'(nr), 128'(m_nr));
   endtask

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   // ---------------- main sequence ----------------
   initial begin
      int c0, words, nk, len;
      logic [255:0] rkey;
      build_sbox();
      rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rk_idx = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_done", 128'(done), 128'd0);
      chk("reset_err", 128'(err), 128'd0);
      chk("reset_key_valid", 128'(key_valid), 128'd0);
      chk("reset_nr", 128'(nr), 128'd0);
      chk("reset_rk_out", rk_out, 128'd0);
      chk("reset_state", 128'(dbg_state), 128'd0);
      rd(0, 128'h0);

      // AES-128 known answer
      run(0, KEY128);
      rd(1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd(0, exp_rk(0));
      rd(11, 128'h0);

      // illegal key length keeps the stored schedule
      @(negedge clk);
      start = 1'b1; key_len = 2'd3;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", 128'(err), 128'd1);
      chk("err_busy", 128'(busy), 128'd0);
      @(negedge clk);
      chk("err_clears", 128'(err), 128'd0);
      chk("err_key_valid", 128'(key_valid), 128'd1);
      chk("err_nr", 128'(nr), 128'd10);
      rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // AES-192 known answer
      run(1, KEY192);
      rd(12, 128'he98ba06f448c773c8ecc720401002202);
      rd(13, 128'h0);

      // AES-256 known answer and out-of-range index
      run(2, KEY256);
      rd(14, 128'hfe4890d1e6188d0b046df344706c631e);
      rd(13, exp_rk(13));
      rd(15, 128'h0);

      // reset twenty cycles into a 256 run
      model_expand(2, KEY256, words, nk);
      m_valid = 0; m_nr = 0;
      @(negedge clk);
      start = 1'b1; key_len = 2'd2; key_in = KEY256;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 128'(busy), 128'd0);
      chk("midrst_key_valid", 128'(key_valid), 128'd0);
      chk("midrst_nr", 128'(nr), 128'd0);
      chk("midrst_rk_out", rk_out, 128'd0);
      chk("midrst_state", 128'(dbg_state), 128'd0);
      repeat (60) @(negedge clk);
      chk("midrst_no_done_busy", 128'(busy), 128'd0);
      run(0, KEY128);
      rd(1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // start held through a 192 run: one done, then a back-to-back run
      model_expand(1, KEY192, words, nk);
      m_valid = 0; m_nr = 0;
      @(negedge clk);
      c0 = cyc;
      start = 1'b1; key_len = 2'd1; key_in = KEY192;
      done_q.push_back(c0 + 47);
      done_q.push_back(c0 + 95);
      while (cyc < c0 + 49) @(negedge clk);
      start = 1'b0;
      wait_quiet();
      m_valid = 1; m_nr = m_nr_nx;
      chk("held_nr", 128'(nr), 128'd12);
      rd(12, 128'he98ba06f448c773c8ecc720401002202);

      // random keys and lengths against the model
      for (int r = 0; r < 5; r++) begin
         len  = $urandom_range(0, 2);
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run(len, rkey);
         for (int k = 0; k < 12; k++) begin
            int idx;
            idx = $urandom_range(0, 15);
            rd(idx, exp_rk(idx));
         end
      end

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expectations actual=%0d_%0d required=0_0", exp_q.size(), done_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
